// File: rtl/debug_unit.sv
// debug_unit: host-side control stage upstream of the MIPS pipeline. Loads
//   program words from UART RX bytes, gates the pipeline for RUN/STEP and
//   reports PC and cycle count back over UART TX.
// Latency: last load byte -> o_prog_we 1 cycle; o_prog_we -> o_mips_clear 1 cycle.
// Backpressure: each TX byte waits for i_tx_done; RX bytes outside IDLE/LOAD are dropped.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-low reset
//   i_rx_data/i_rx_done   received byte and its one-cycle strobe
//   o_tx_data/o_tx_start  byte to send (held until i_tx_done) and start strobe
//   i_tx_done             TX finished current byte
//   o_prog_we/_addr/_data program-memory write port
//   o_mips_en/o_mips_clear pipeline clock-enable and synchronous clear
//   i_halt, i_pc          pipeline halt level and current PC
//
// Optional feature: define DEBUG_UNIT_TIMEOUT_EN to abort a stalled LOAD after
// TIMEOUT_CYCLES idle cycles (sends 8'hEE, returns to IDLE). The TIMEOUT_CYCLES
// parameter exists only in that build.

module debug_unit #(
  parameter int LEN               = 32,
  parameter int NB_ADDRESS        = 16,
  parameter int RAM_DEPTH_PROGRAM = 32,
  parameter int NB_BYTE           = 8
`ifdef DEBUG_UNIT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES    = 1024
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_prog_we,
  output logic [NB_ADDRESS-1:0] o_prog_addr,
  output logic [LEN-1:0]        o_prog_data,
  output logic                  o_mips_en,
  output logic                  o_mips_clear,
  input  logic                  i_halt,
  input  logic [LEN-1:0]        i_pc
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_CNT  = 3'd1;
  localparam logic [2:0] ST_LOAD_BYTE = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_CLEAR     = 3'd4;
  localparam logic [2:0] ST_RUN       = 3'd5;
  localparam logic [2:0] ST_STEP      = 3'd6;
  localparam logic [2:0] ST_SEND      = 3'd7;

  localparam int BYTES_PER_WORD = LEN / NB_BYTE;
  localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int REP_W          = 2 * LEN;
  localparam int REP_BYTES      = REP_W / NB_BYTE;
  localparam int LEFT_W         = $clog2(REP_BYTES + 1);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);

  logic [2:0]            state_q, state_d;
  logic [NB_ADDRESS-1:0] n_q, n_d;               // words to load (saturated)
  logic [NB_ADDRESS-1:0] word_idx_q, word_idx_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [LEN-1:0]        word_q, word_d;         // word being assembled, MSB first
  logic [LEN-1:0]        cnt_q, cnt_d;           // enabled-cycle counter
  logic [REP_W-1:0]      report_q, report_d;     // outgoing bytes, top byte is current
  logic [LEFT_W-1:0]     left_q, left_d;         // bytes still to send incl. current
  logic                  tx_pend_q, tx_pend_d;   // current byte not yet started
  logic                  step_done_q, step_done_d;

`ifdef DEBUG_UNIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    report_d    = report_q;
    left_d      = left_q;
    tx_pend_d   = tx_pend_q;
    step_done_d = step_done_q;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d = ST_LOAD_CNT;
          end else if (i_rx_data == CMD_RUN) begin
            state_d = ST_RUN;
          end else if (i_rx_data == CMD_STEP) begin
            state_d     = ST_STEP;
            step_done_d = 1'b0;
          end
        end
      end

      ST_LOAD_CNT: begin
        if (i_rx_done) begin
          word_idx_d = '0;
          byte_idx_d = '0;
          if (i_rx_data == '0) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_LOAD_BYTE;
            if (NB_ADDRESS'(i_rx_data) > NB_ADDRESS'(RAM_DEPTH_PROGRAM)) begin
              n_d = NB_ADDRESS'(RAM_DEPTH_PROGRAM);
            end else begin
              n_d = NB_ADDRESS'(i_rx_data);
            end
          end
        end
      end

      ST_LOAD_BYTE: begin
        if (i_rx_done) begin
          word_d     = {word_q[LEN-NB_BYTE-1:0], i_rx_data};
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        byte_idx_d = '0;
        if (word_idx_q + 1'b1 == n_q) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_LOAD_BYTE;
        end
      end

      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      ST_RUN: begin
        if (i_halt) begin
          report_d  = {i_pc, cnt_q};
          left_d    = LEFT_W'(REP_BYTES);
          tx_pend_d = 1'b1;
          state_d   = ST_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // First cycle issues the single enable pulse; the capture happens the
      // cycle after so the reported PC reflects the stepped instruction.
      ST_STEP: begin
        if (i_halt || step_done_q) begin
          report_d  = {i_pc, cnt_q};
          left_d    = LEFT_W'(REP_BYTES);
          tx_pend_d = 1'b1;
          state_d   = ST_SEND;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          step_done_d = 1'b1;
        end
      end

      ST_SEND: begin
        if (tx_pend_q) begin
          tx_pend_d = 1'b0;
        end else if (i_tx_done) begin
          if (left_q == LEFT_W'(1)) begin
            state_d = ST_IDLE;
            left_d  = '0;
          end else begin
            left_d    = left_q - 1'b1;
            report_d  = {report_q[REP_W-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
            tx_pend_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef DEBUG_UNIT_TIMEOUT_EN
    to_cnt_d = '0;
    if (state_q == ST_LOAD_CNT || state_q == ST_LOAD_BYTE) begin
      if (!i_rx_done) begin
        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort: drop the partial word, report a single error byte.
          report_d                        = '0;
          report_d[REP_W-1 -: NB_BYTE]    = NB_BYTE'(8'hEE);
          left_d                          = LEFT_W'(1);
          tx_pend_d                       = 1'b1;
          byte_idx_d                      = '0;
          state_d                         = ST_SEND;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      report_q    <= '0;
      left_q      <= '0;
      tx_pend_q   <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      report_q    <= report_d;
      left_q      <= left_d;
      tx_pend_q   <= tx_pend_d;
      step_done_q <= step_done_d;
    end
  end

`ifdef DEBUG_UNIT_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // Outputs decode from state so reset forces them low immediately. The enable
  // also looks at i_halt so the halting cycle itself is never enabled.
  assign o_prog_we    = (state_q == ST_WRITE);
  assign o_prog_addr  = (state_q == ST_WRITE) ? word_idx_q : '0;
  assign o_prog_data  = (state_q == ST_WRITE) ? word_q : '0;
  assign o_mips_clear = (state_q == ST_CLEAR);
  assign o_mips_en    = ((state_q == ST_RUN) && !i_halt) ||
                        ((state_q == ST_STEP) && !i_halt && !step_done_q);
  assign o_tx_start   = (state_q == ST_SEND) && tx_pend_q;
  assign o_tx_data    = (state_q == ST_SEND) ? report_q[REP_W-1 -: NB_BYTE] : '0;

endmodule

// File: tb/tb_debug_unit.sv
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        prog_we;
  logic [15:0] prog_addr;
  logic [31:0] prog_data;
  logic        mips_en;
  logic        mips_clear;
  logic        halt;
  logic [31:0] pc;

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_done   (tx_done),
    .o_prog_we   (prog_we),
    .o_prog_addr (prog_addr),
    .o_prog_data (prog_data),
    .o_mips_en   (mips_en),
    .o_mips_clear(mips_clear),
    .i_halt      (halt),
    .i_pc        (pc)
  );

  // kind: 0 = program write, 1 = pipeline clear, 2 = TX byte
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   en_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_event(input int kind, input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h required none", kind, addr, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.addr !== addr || e.data !== data) begin
        bad++;
        $display("FAIL event: got kind=%0d addr=%0h data=%0h required kind=%0d addr=%0h data=%0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mips_en)    en_cycles++;
    if (prog_we)    chk_event(0, prog_addr, prog_data);
    if (mips_clear) chk_event(1, 16'h0, 32'h0);
    if (tx_start)   chk_event(2, 16'h0, {24'h0, tx_data});
  end

  // UART TX model: finishes each started byte a few cycles later.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (3) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  function automatic exp_t mk(input int kind, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic exp_wr(input logic [15:0] a, input logic [31:0] d);
    q.push_back(mk(0, a, d));
  endtask

  task automatic exp_clr();
    q.push_back(mk(1, 16'h0, 32'h0));
  endtask

  task automatic exp_report(input logic [31:0] p, input logic [31:0] c);
    logic [63:0] r;
    r = {p, c};
    for (int i = 0; i < 8; i++) q.push_back(mk(2, 16'h0, {24'h0, r[63-8*i -: 8]}));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b; rx_done = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0; rx_data = 8'h00;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, 64'(q.size()), 64'd0);
    q.delete();
    repeat (10) @(posedge clk);
  endtask

  int e0;
  int k;
  logic [31:0] w;

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; halt = 1'b0; pc = 32'h0;
    #1;
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_prog_we",  64'(prog_we),  64'd0);
    check("rst_mips_en",  64'(mips_en),  64'd0);
    check("rst_clear",    64'(mips_clear), 64'd0);
    check("rst_tx_data",  64'(tx_data),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset in the middle of RUN drops enable immediately
    send_byte(8'h52);
    repeat (3) @(posedge clk);
    #1 check("run_en_active", 64'(mips_en), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("midrun_rst_en", 64'(mips_en), 64'd0);
    check("midrun_rst_tx", 64'(tx_start), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("after_rst_idle_en", 64'(mips_en), 64'd0);

    // 2: load two words
    exp_wr(16'd0, 32'hDEADBEEF);
    exp_wr(16'd1, 32'h00000001);
    exp_clr();
    send_byte(8'h4C); send_byte(8'd2);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    drain("load2", 50);

    // 3: single step; an 'S' arriving during SEND must be dropped
    pc = 32'h4;
    e0 = en_cycles;
    exp_report(32'h4, 32'h1);
    send_byte(8'h53);
    repeat (8) @(posedge clk);
    send_byte(8'h53);
    drain("step", 200);
    check("step_en_cycles", 64'(en_cycles - e0), 64'd1);

    // 4: run until halt after ten enabled cycles
    pc = 32'h28;
    e0 = en_cycles;
    exp_report(32'h28, 32'h0B);
    send_byte(8'h52);
    k = 0;
    while ((en_cycles - e0) < 10 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("run_reached_10", 64'(en_cycles - e0), 64'd10);
    #1 halt = 1'b1;
    drain("run", 200);
    check("run_en_cycles", 64'(en_cycles - e0), 64'd10);
    halt = 1'b0;

    // 5: unknown byte ignored in IDLE
    e0 = en_cycles;
    send_byte(8'h58);
    repeat (10) @(posedge clk);
    check("x_ignored_en", 64'(en_cycles - e0), 64'd0);

    // 5: zero-length load gives a clear and no writes
    exp_clr();
    send_byte(8'h4C); send_byte(8'h00);
    drain("load0", 20);

    // 5: 40 requested words saturate to 32
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'hA5, 8'h5A, ~8'(i)};
      exp_wr(16'(i), w);
    end
    exp_clr();
    send_byte(8'h4C); send_byte(8'd40);
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'hA5, 8'h5A, ~8'(i)};
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    end
    drain("load40", 50);

    // 6: without the timeout build a stalled load waits indefinitely
    send_byte(8'h4C); send_byte(8'd1); send_byte(8'hAA);
    repeat (60) @(posedge clk);
    check("stall_queue_quiet", 64'(q.size()), 64'd0);
    exp_wr(16'd0, 32'hAABBCCDD);
    exp_clr();
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    drain("stall_resume", 50);

    // step after load clear reports count 1 again
    pc = 32'h8;
    exp_report(32'h8, 32'h1);
    send_byte(8'h53);
    drain("step2", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
